// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// State encoding doubles as the occupancy count.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 4;

    localparam int LANE_PC  = 0;
    localparam int LANE_RS1 = 1;
    localparam int LANE_RS2 = 2;
    localparam int LANE_IMM = 3;

    function automatic logic [1:0] occ_of(input state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Up-counter taking 0..2 per cycle, clamped at all-ones.
// Used to tally entries discarded by a pipeline flush.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W+1:0] sum;

    always_comb begin
        sum   = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
        cnt_d = (sum > MAX) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with optional 2-entry skid
// buffer, synchronous flush and a saturating drop counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LANES       = DEF_LANES,
    parameter int SKID_EN     = 1,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int PW = LANES * DATA_W;

    state_e          state_q;
    state_e          state_d;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   main_d;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   skid_d;
    logic            ready_q;
    logic            in_fire;
    logic            out_fire;
    logic [1:0]      drop_inc;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = occ_of(state_q);

    // With the skid buffer, in_ready comes straight from a flop.
    assign in_ready = !flush &&
        ((SKID_EN != 0) ? ready_q : (!out_valid || out_ready));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        drop_inc = 2'd0;
        if (flush) begin
            state_d  = ST_EMPTY;
            drop_inc = occupancy - {1'b0, out_fire};
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && SKID_EN != 0) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            if (SKID_EN != 0) begin
                skid_q <= skid_d;
            end
            ready_q <= (state_d != ST_TWO);
        end
    end

    assign out_data = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : main_q;

    sat_counter #(
        .W(CNT_W)
    ) u_drop (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench: three stage variants share one stimulus stream,
// each checked against its own FIFO reference model every cycle.
module tb_pipe_skid_stage;

    localparam int PW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_data   = '0;

    logic          ov  [3];
    logic          ir  [3];
    logic [1:0]    occ [3];
    logic [PW-1:0] od  [3];
    logic [15:0]   dc_a;
    logic [1:0]    dc_b;
    logic [15:0]   dc_c;

    pipe_skid_stage #(.SKID_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .drop_cnt(dc_a)
    );

    pipe_skid_stage #(.SKID_EN(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .drop_cnt(dc_b)
    );

    pipe_skid_stage #(.SKID_EN(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .drop_cnt(dc_c)
    );

    localparam int SKID[3]   = '{1, 1, 0};
    localparam int SATMAX[3] = '{65535, 3, 65535};

    logic [PW-1:0] q [3][$];
    int drop_m [3];
    int fires  [3];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string n,
                                input logic [PW-1:0] act,
                                input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endfunction

    // Monitor: compare every DUT against its model, then advance the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int om;
            logic irm;
            logic ofire;
            logic [15:0] dcv;
            if (rst) begin
                q[d].delete();
                drop_m[d] = 0;
                continue;
            end
            dcv = (d == 0) ? dc_a : (d == 1) ? {14'd0, dc_b} : dc_c;
            om  = q[d].size();
            irm = !flush && ((SKID[d] != 0) ? (om < 2)
                                            : (om == 0 || out_ready));
            chk($sformatf("in_ready[%0d]", d), PW'(ir[d]), PW'(irm));
            chk($sformatf("out_valid[%0d]", d), PW'(ov[d]), PW'(om > 0));
            chk($sformatf("occupancy[%0d]", d), PW'(occ[d]), PW'(om));
            chk($sformatf("drop_cnt[%0d]", d), PW'(dcv), PW'(drop_m[d]));
            if (om > 0) chk($sformatf("out_data[%0d]", d), od[d], q[d][0]);
            else        chk($sformatf("bubble[%0d]", d), od[d], '0);
            ofire = (om > 0) && out_ready;
            if (ofire) fires[d]++;
            if (flush) begin
                drop_m[d] += om - int'(ofire);
                if (drop_m[d] > SATMAX[d]) drop_m[d] = SATMAX[d];
                q[d].delete();
            end else begin
                if (ofire) void'(q[d].pop_front());
                if (in_valid && irm) q[d].push_back(in_data);
            end
        end
    end

    task automatic step(input logic v, input logic [PW-1:0] d,
                        input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        for (int d = 0; d < 3; d++) fires[d] = 0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", PW'(ir[0]), 1);
        chk("rst_drop", PW'(dc_a), 0);

        step(1'b1, PW'(32'h100), 1'b1, 1'b0);
        chk("pass_valid", PW'(ov[0]), 1);
        chk("pass_lane0", PW'(od[0][31:0]), PW'(32'h100));
        chk("pass_occ", PW'(occ[0]), 1);
        chk("pass_ready", PW'(ir[0]), 1);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, PW'(4'hA), 1'b0, 1'b0);
        step(1'b1, PW'(4'hB), 1'b0, 1'b0);
        chk("bp_occ", PW'(occ[0]), 2);
        chk("bp_ready", PW'(ir[0]), 0);
        chk("bp_first", od[0], PW'(4'hA));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_second", od[0], PW'(4'hB));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", PW'(occ[0]), 0);

        base = fires[0];
        for (int i = 1; i <= 16; i++) step(1'b1, PW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_fires", PW'(fires[0] - base), 16);

        step(1'b1, PW'(4'hA), 1'b0, 1'b0);
        step(1'b1, PW'(4'hB), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush_valid", PW'(ov[0]), 0);
        chk("flush_data", od[0], '0);
        chk("flush_occ", PW'(occ[0]), 0);
        chk("flush_drop", PW'(dc_a), 2);
        step(1'b1, PW'(4'hC), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("flush_deliver", PW'(dc_a), 2);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, PW'(4'hD), 1'b0, 1'b0);
            step(1'b1, PW'(4'hE), 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b1);
        end
        chk("sat_b", PW'(dc_b), 3);
        chk("sat_a", PW'(dc_a), 10);
        step(1'b1, PW'(4'hD), 1'b0, 1'b0);
        step(1'b1, PW'(4'hE), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("sat_hold", PW'(dc_b), 3);

        step(1'b1, PW'(4'hF), 1'b1, 1'b0);
        in_valid  = 1'b1;
        in_data   = PW'(8'h10);
        out_ready = 1'b0;
        #1;
        chk("ns_ready_same", PW'(ir[2]), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, PW'(8'h55), 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_occ", PW'(occ[0]), 0);
        chk("rst_mid_drop", PW'(dc_a), 0);

        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
